// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mux_arb_pkg
//  Brief  : Shared defaults, index type and slot-state encoding for the
//           round-robin mux arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
package mux_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    typedef logic [$clog2(N_REQ_DEF)-1:0] idx_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module : mux_rr_arbiter_if
//  Brief  : Requester bundle plus single output-slot handshake.
//  Rev    : 1.0  initial release
// ============================================================================
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) ();

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic [IDX_W-1:0]   out_src;
    logic               out_ready;

    // master = environment (producers + consumer), slave = arbiter
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin pick: rotate, fixed-priority encode,
//           rotate the winning offset back into an absolute index.
//  Rev    : 1.0  initial release
// ============================================================================
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic [IDX_W-1:0] last_i,
    output logic      [IDX_W-1:0] grant_o,
    output logic                  any_o
);

    // One extra bit holds start + offset (at most 2*N_REQ-2) without overflow
    localparam int SW = IDX_W + 1;

    logic [SW-1:0]      w_start;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SW-1:0]      w_off;
    logic [SW-1:0]      w_sum;

    always_comb begin
        w_start = (last_i == IDX_W'(N_REQ - 1)) ? '0 : SW'(last_i) + SW'(1);
        w_dbl   = {req_i, req_i};
        w_rot   = w_dbl[w_start +: N_REQ];

        w_off = '0;
        any_o = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = SW'(j);
                any_o = 1'b1;
            end
        end

        w_sum = w_start + w_off;
        if (w_sum >= SW'(N_REQ)) begin
            w_sum = w_sum - SW'(N_REQ);
        end
        grant_o = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : mux_rr_arbiter
//  Brief  : Round-robin arbiter feeding one registered output slot through an
//           N_REQ:1 data mux; full throughput via drain-and-load.
//  Rev    : 1.0  initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mux_rr_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(N_REQ);

    slot_state_e      state_q;
    logic [W-1:0]     data_q;
    logic [IDX_W-1:0] src_q;
    logic [IDX_W-1:0] last_q;

    logic             w_load_ok;
    logic             w_any;
    logic             w_xfer;
    logic [IDX_W-1:0] w_grant;
    logic [W-1:0]     w_sel_data;
    logic [W-1:0]     w_data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = bus.req_data[gi*W +: W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (w_grant),
        .any_o   (w_any)
    );

    assign w_load_ok  = (state_q == EMPTY) || bus.out_ready;
    // Reset gating keeps every ready low while rst is held
    assign w_xfer     = !rst && w_load_ok && w_any;
    assign w_sel_data = w_data_arr[w_grant];

    always_comb begin
        bus.req_ready = '0;
        if (w_xfer) begin
            bus.req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else if (w_xfer) begin
            state_q <= FULL;
            data_q  <= w_sel_data;
            src_q   <= w_grant;
            last_q  <= w_grant;
        end else if (state_q == FULL && bus.out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : tb_mux_rr_arbiter
//  Brief  : Directed bench for mux_rr_arbiter with a scan-based reference
//           model checked every cycle plus literal expectations.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    mux_rr_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: slot contents and pointer to the most recent winner
    bit          m_valid;
    logic [7:0]  m_data;
    int          m_src;
    int          m_last;

    function automatic logic [N-1:0] exp_ready();
        if (rst) return '0;
        if (m_valid && !bus.out_ready) return '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (bus.req_valid[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    initial begin
        logic [N-1:0] r;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = N - 1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            r = exp_ready();
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("m_out_data",  32'(bus.out_data),  32'(m_data));
            chk("m_out_src",   32'(bus.out_src),   m_src);
            chk("m_req_ready", 32'(bus.req_ready), 32'(r));
            if (rst) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_src   = 0;
                m_last  = N - 1;
            end else if (r != '0) begin
                for (int g = 0; g < N; g++) begin
                    if (r[g]) begin
                        m_data = bus.req_data[g*W +: W];
                        m_src  = g;
                        m_last = g;
                    end
                end
                m_valid = 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rdy_seq   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rdy_sparse[4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

    initial begin
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.out_ready = 1'b1;

        // Reset held: no ready even with all requests pending
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 0);
        tick();
        rst = 1'b0;

        // Reset priority: requester 0 first, then one word per cycle
        @(negedge clk);
        chk("post_rst_valid", 32'(bus.out_valid), 0);
        chk("post_rst_data",  32'(bus.out_data),  0);
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("prio_valid", 32'(bus.out_valid), 1);
            chk("prio_data",  32'(bus.out_data),  32'h10 + i);
            chk("prio_src",   32'(bus.out_src),   i);
            chk("prio_ready", 32'(bus.req_ready), 32'(rdy_seq[i]));
        end
        tick();

        // Backpressure: load A5 from requester 2, then stall five cycles
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        @(negedge clk);
        chk("bp_load_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data",  32'(bus.out_data),  32'hA5);
            chk("bp_ready", 32'(bus.req_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'h8);
        tick();

        // Sparse requests 0 and 3 alternate across the wrap
        bus.req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sparse_ready", 32'(bus.req_ready), 32'(rdy_sparse[i]));
            tick();
        end

        // Drain and load in the same cycle: no bubble between 01 and 02
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h01};
        @(negedge clk);
        chk("dl_first_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0010;
        bus.req_data  = {8'h13, 8'h12, 8'h02, 8'h01};
        @(negedge clk);
        chk("dl_old_data",  32'(bus.out_data),  32'h01);
        chk("dl_ready",     32'(bus.req_ready), 32'h2);
        tick();

        // Idle: slot drains, pointer stays on requester 1
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("dl_new_valid", 32'(bus.out_valid), 1);
        chk("dl_new_data",  32'(bus.out_data),  32'h02);
        chk("dl_new_src",   32'(bus.out_src),   1);
        tick();
        @(negedge clk);
        chk("idle_valid", 32'(bus.out_valid), 0);
        tick();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("idle_single_ready", 32'(bus.req_ready), 32'h2);
        tick();

        // Reset while full and stalled
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_stall_valid", 32'(bus.out_valid), 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.req_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_valid", 32'(bus.out_valid), 0);
        chk("mid_post_ready", 32'(bus.req_ready), 32'h1);
        tick();

        // Mixed traffic, checked by the model alone
        for (int i = 0; i < 40; i++) begin
            bus.req_valid = 4'($urandom);
            bus.req_data  = 32'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one registered output channel among `N_REQ` requesters. Each cycle it picks one requester, routes that requester's data through an `N_REQ`:1 select mux, and loads the data into a single output slot. The block is the controller for the mux datapath: it owns the select, the per-requester ready signals and the output valid/ready handshake. It sits between independent producers and one downstream consumer.

## Interface
- `N_REQ`, 4: number of requesters; must be ≥ 2.
- `W`, 8: data width per requester.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  `N_REQ`  per-requester valid.
- `req_data`  in  `N_REQ*W`  flattened data; requester i occupies bits `[i*W +: W]`.
- `req_ready`  out  `N_REQ`  per-requester ready; at most one bit is high in any cycle.
- `out_valid`  out  1  output slot holds a word.
- `out_data`  out  `W`  held word.
- `out_src`  out  `$clog2(N_REQ)`  index of the requester that supplied `out_data`.
- `out_ready`  in  1  downstream accepts the word.

## Operation
- **Slot FSM.** Two states, `EMPTY` and `FULL`. `out_valid` is 1 exactly when the state is `FULL`.
- **Load enable.** `load_ok = !out_valid || out_ready`.
- **Pick.** Scan indices starting at `last+1` and wrapping modulo `N_REQ`. The first i with `req_valid[i]` wins (the grant). `last` is the pointer to the most recent winner.
- **Ready.** `req_ready[i] = load_ok && (i == grant) && any(req_valid)`. This is combinational from `req_valid`, `out_valid` and `out_ready`; there is no combinational path from `req_data`.
- **Transfer.** A transfer happens when `req_valid[i] && req_ready[i]`. On the next edge:
  - `out_data` ← `req_data[grant]` through the mux;
  - `out_src` ← grant;
  - `last` ← grant;
  - state ← `FULL`.
- **Drain.** `out_valid && out_ready` with no transfer in the same cycle: state ← `EMPTY`. `out_data` and `out_src` keep their old values (don't-care).
- **Drain and load in the same cycle.** The slot is replaced by the new word and the state stays `FULL`. This gives full throughput.
- **No request.** No transfer happens and `last` is unchanged.
- **Stability.** While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_src` are held constant and every `req_ready` bit is 0.
- **Fairness.** Each requester that holds `req_valid` continuously is granted within `N_REQ` transfers.
- **Requester withdrawal.** A requester may drop `req_valid` without completing a transfer; the arbiter tolerates this.

## Timing
- **Reset values:**
  - state `EMPTY`, `out_valid` 0;
  - `out_data` 0, `out_src` 0;
  - `last` = `N_REQ-1`, so requester 0 has first priority after reset;
  - `req_ready` 0 during reset.
- **Latency.** A transfer in cycle t produces `out_valid` = 1 with the new data in cycle t+1.
- **Throughput.** One word per cycle when `out_ready` is held at 1.
- **Reset mid-operation.** A held word is discarded; there is no drain. The pointer returns to `N_REQ-1`.
- **Wrap-around.** When `last` = `N_REQ-1`, the scan starts at index 0.
- **Single requester.** Only requester k valid and the slot always draining: k is granted every cycle.

## Structure
- **Package `mux_arb_pkg`:**
  - localparam defaults for `N_REQ` and `W`;
  - `idx_t` typedef (width `$clog2(N_REQ)`);
  - slot state enum (`EMPTY`, `FULL`).
- **Sub-module `rr_pick`.** Combinational. Inputs: `req` vector and `last` index. Outputs: `grant` index and `any` flag. Method: rotate the request vector, apply a fixed priority encoder, rotate the result back.
- **Top module:**
  - the slot FSM;
  - the `last` register;
  - the ready decode;
  - the `N_REQ`:1 data select mux driven by `grant`.

## Test plan
- **Reset priority.** After reset, `req_valid`=4'b1111, `out_ready`=1, data i = 8'h10+i → `out_src` sequence 0,1,2,3,0… and `out_data` 8'h10,8'h11,8'h12,8'h13, one word per cycle starting the cycle after the first transfer.
- **Backpressure.** Load 8'hA5 from requester 2, then hold `out_ready`=0 for 5 cycles with all requests valid → `out_valid`=1 and `out_data`=8'hA5 stable; `req_ready`=0 throughout. Then release → next grant is requester 3.
- **Sparse requests and wrap.** `req_valid`=4'b1001 continuously → grants alternate 0,3,0,3; requesters 1 and 2 never get ready.
- **Simultaneous drain and load.** Slot `FULL` with 8'h01, `out_ready`=1, requester 1 valid with 8'h02 → next cycle `out_valid`=1 and `out_data`=8'h02, with no empty bubble.
- **Idle.** All `req_valid`=0, slot drained → `out_valid` falls to 0 and `last` is unchanged. A following single request from requester 1 is granted immediately.
- **Reset mid-operation.** Assert `rst` while `FULL` and stalled → next cycle `out_valid`=0. After release, all-valid requests are granted starting at requester 0.
